// File: rtl/approx_err_pkg.sv
// Shared definitions for the approximate-arithmetic error profilers:
// FSM state encoding and accumulator width helpers derived from operand width.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Width of the |err| accumulator: 2^(2W) pairs times a (W+1)-bit distance.
  function automatic int sum_w(input int w);
    return 3 * w + 1;
  endfunction

  // Width of the erroneous-pair counter: must hold 2^(2W) itself.
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  // Width of the err^2 accumulator: 2^(2W) pairs times a (2W+2)-bit square.
  function automatic int sq_w(input int w);
    return 4 * w + 2;
  endfunction

endpackage

// File: rtl/approx_err_dist.sv
// Combinational error distance between an approximate result and the exact
// result: absolute difference and its square. Shared with the multiplier profiler.
module approx_err_dist
  import approx_err_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W:0]     o,
  input  logic [W:0]     exact,
  output logic [W:0]     d,
  output logic [2*W+1:0] d_sq
);

  logic [2*W+1:0] d_ext_s;

  // Absolute difference of the two unsigned values, then its square.
  always_comb begin
    d       = {(W+1){1'b0}};
    d_ext_s = {(2*W+2){1'b0}};
    d_sq    = {(2*W+2){1'b0}};
    if (o >= exact) begin
      d = o - exact;
    end else begin
      d = exact - o;
    end
    d_ext_s = {{(W+1){1'b0}}, d};
    d_sq    = d_ext_s * d_ext_s;
  end

endmodule

// File: rtl/approx_add_err_profiler.sv
// Exhaustive error profiler for W-bit approximate adders. Sweeps every {A,B}
// pair into an external combinational adder, then accumulates total |err|,
// max |err|, erroneous-pair count and total err^2 through a two-stage pipeline.
module approx_add_err_profiler
  import approx_err_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [W-1:0]          dut_a,
  output logic [W-1:0]          dut_b,
  input  logic [W:0]            dut_o,
  output logic                  busy,
  output logic                  done,
  output logic [sum_w(W)-1:0]   err_sum,
  output logic [W:0]            err_max,
  output logic [cnt_w(W)-1:0]   err_cnt,
  output logic [sq_w(W)-1:0]    sq_sum
);

  localparam int CW  = 2 * W;
  localparam int SW  = sum_w(W);
  localparam int NW  = cnt_w(W);
  localparam int QW  = sq_w(W);
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e          state_r;
  state_e          state_s;
  logic [CW-1:0]   cnt_r;
  logic            accept_s;
  logic            last_s;
  logic            s1_valid_r;
  logic [W:0]      s1_o_r;
  logic [W:0]      s1_exact_r;
  logic [W:0]      d_s;
  logic [2*W+1:0]  d_sq_s;
  logic            busy_r;
  logic            done_r;
  logic [SW-1:0]   err_sum_r;
  logic [W:0]      err_max_r;
  logic [NW-1:0]   err_cnt_r;
  logic [QW-1:0]   sq_sum_r;

  assign accept_s = (state_r == IDLE) && start;
  assign last_s   = (cnt_r == CNT_LAST);

  // The operand counter drives the adder directly: A is the upper half.
  assign dut_a   = cnt_r[CW-1:W];
  assign dut_b   = cnt_r[W-1:0];
  assign busy    = busy_r;
  assign done    = done_r;
  assign err_sum = err_sum_r;
  assign err_max = err_max_r;
  assign err_cnt = err_cnt_r;
  assign sq_sum  = sq_sum_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: RUN ends once the last operand is on the bus, DRAIN
  // covers the single remaining accumulate of that operand.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered status flags; done marks the edge of the final accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == DRAIN);
    end
  end

  // Operand counter: zeroed on an accepted start, steps once per RUN cycle
  // and holds at the last pair so operand 0 is never re-issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == RUN) && !last_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1: capture the adder result alongside the exact sum of the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_o_r     <= {(W+1){1'b0}};
      s1_exact_r <= {(W+1){1'b0}};
    end else begin
      s1_valid_r <= (state_r == RUN);
      s1_o_r     <= dut_o;
      s1_exact_r <= {1'b0, dut_a} + {1'b0, dut_b};
    end
  end

  approx_err_dist #(
    .W (W)
  ) u_dist (
    .o     (s1_o_r),
    .exact (s1_exact_r),
    .d     (d_s),
    .d_sq  (d_sq_s)
  );

  // Stage 2: accumulate statistics; widths make overflow impossible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_r <= {SW{1'b0}};
      err_max_r <= {(W+1){1'b0}};
      err_cnt_r <= {NW{1'b0}};
      sq_sum_r  <= {QW{1'b0}};
    end else if (accept_s) begin
      err_sum_r <= {SW{1'b0}};
      err_max_r <= {(W+1){1'b0}};
      err_cnt_r <= {NW{1'b0}};
      sq_sum_r  <= {QW{1'b0}};
    end else if (s1_valid_r) begin
      err_sum_r <= err_sum_r + {{(SW-W-1){1'b0}}, d_s};
      sq_sum_r  <= sq_sum_r + {{(QW-2*W-2){1'b0}}, d_sq_s};
      if (d_s != {(W+1){1'b0}}) begin
        err_cnt_r <= err_cnt_r + {{(NW-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_r <= err_cnt_r;
      end
      if (d_s > err_max_r) begin
        err_max_r <= d_s;
      end else begin
        err_max_r <= err_max_r;
      end
    end else begin
      err_sum_r <= err_sum_r;
      err_max_r <= err_max_r;
      err_cnt_r <= err_cnt_r;
      sq_sum_r  <= sq_sum_r;
    end
  end

endmodule

// File: tb/tb_approx_add_err_profiler.sv
// Directed bench for approx_add_err_profiler using a behavioural adder whose
// error model is selectable. Operand width 4 keeps each sweep at 256 pairs.
module tb_approx_add_err_profiler;
  import approx_err_pkg::*;

  localparam int W = 4;
  localparam int N = 1 << (2 * W);

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [W-1:0]        dut_a;
  logic [W-1:0]        dut_b;
  logic [W:0]          dut_o;
  logic                busy;
  logic                done;
  logic [sum_w(W)-1:0] err_sum;
  logic [W:0]          err_max;
  logic [cnt_w(W)-1:0] err_cnt;
  logic [sq_w(W)-1:0]  sq_sum;

  int mode;
  int checks = 0;
  int passed = 0;

  typedef struct {
    longint sum;
    longint max;
    longint cnt;
    longint sq;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  approx_add_err_profiler #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dut_a   (dut_a),
    .dut_b   (dut_b),
    .dut_o   (dut_o),
    .busy    (busy),
    .done    (done),
    .err_sum (err_sum),
    .err_max (err_max),
    .err_cnt (err_cnt),
    .sq_sum  (sq_sum)
  );

  // Adder under test: 0 exact, 1 stuck-zero, 2 LSB forced, 3 single fault at max operands.
  always_comb begin
    dut_o = {(W+1){1'b0}};
    case (mode)
      0: dut_o = {1'b0, dut_a} + {1'b0, dut_b};
      1: dut_o = {(W+1){1'b0}};
      2: dut_o = ({1'b0, dut_a} + {1'b0, dut_b}) | {{W{1'b0}}, 1'b1};
      3: dut_o = {1'b0, dut_a} + {1'b0, dut_b} +
                 (((dut_a == {W{1'b1}}) && (dut_b == {W{1'b1}})) ? (W+1)'(16) : {(W+1){1'b0}});
      default: dut_o = {(W+1){1'b0}};
    endcase
  end

  // Closed-form statistics for W=4 (a,b in 0..15).
  function automatic exp_t expect_for(input int m);
    exp_t e;
    case (m)
      1:       e = '{sum: 3840, max: 30, cnt: 255, sq: 68480};
      2:       e = '{sum: 128,  max: 1,  cnt: 128, sq: 128};
      3:       e = '{sum: 16,   max: 16, cnt: 1,   sq: 256};
      default: e = '{sum: 0,    max: 0,  cnt: 0,   sq: 0};
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Accept a sweep now (caller is #1 after an edge), optionally pulse start
  // again at RUN cycle ign_at, then compare results against the scoreboard.
  task automatic run_sweep(input int m, input int ign_at);
    exp_t e;
    int   lat;
    mode  = m;
    sb_q.push_back(expect_for(m));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("operand0", {56'd0, dut_a, dut_b}, 64'd0);
    lat = 0;
    while (done !== 1'b1 && lat < N + 20) begin
      start = (lat == ign_at) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
      if (lat == 7) check("operand7", {56'd0, dut_a, dut_b}, 64'd7);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(N + 1));
    check("done_at_end", {63'd0, done}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    e = sb_q.pop_front();
    check("err_sum", 64'(err_sum), 64'(e.sum));
    check("err_max", 64'(err_max), 64'(e.max));
    check("err_cnt", 64'(err_cnt), 64'(e.cnt));
    check("sq_sum",  64'(sq_sum),  64'(e.sq));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_ops"}, {56'd0, dut_a, dut_b}, 64'd0);
    check({tag, "_sum"}, 64'(err_sum), 64'd0);
    check({tag, "_max"}, 64'(err_max), 64'd0);
    check({tag, "_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_sq"}, 64'(sq_sum), 64'd0);
  endtask

  initial begin
    int saw_done;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle");

    // Exact adder, then stuck-zero started in the same cycle done is high.
    run_sweep(0, -1);
    run_sweep(1, -1);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", 64'(err_sum), 64'd3840);
    check("hold_cnt", 64'(err_cnt), 64'd255);

    run_sweep(2, -1);
    run_sweep(3, -1);

    // Start pulsed mid-RUN must not restart the sweep.
    run_sweep(1, 100);

    // Reset in the middle of a sweep aborts it with no done pulse.
    mode  = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("abort_async");
    @(posedge clk); #1;
    check_all_zero("abort_edge");
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    check("no_done_after_abort", 64'(saw_done), 64'd0);
    check("idle_after_abort", {63'd0, busy}, 64'd0);
    run_sweep(3, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
